// File: rtl/dice_pkg.sv
// Shared types and constants for the dice result tracker slice.
package dice_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ROLLING = 2'd1,
      SETTLE  = 2'd2
   } state_t;

   localparam logic [2:0] FACE_MIN = 3'd1;
   localparam logic [2:0] FACE_MAX = 3'd6;

   localparam int DEF_COUNT_W = 8;

   // Display codes, bit order gfedcba, active-high
   localparam logic [6:0] SEG_BLANK = 7'b0000000;
   localparam logic [6:0] SEG_1     = 7'b0000110;
   localparam logic [6:0] SEG_2     = 7'b1011011;
   localparam logic [6:0] SEG_3     = 7'b1001111;
   localparam logic [6:0] SEG_4     = 7'b1100110;
   localparam logic [6:0] SEG_5     = 7'b1101101;
   localparam logic [6:0] SEG_6     = 7'b1111101;

   function automatic logic is_legal_face(input logic [2:0] f);
      return (f >= FACE_MIN) && (f <= FACE_MAX);
   endfunction

endpackage

// File: rtl/dice_result_tracker_if.sv
// Bus bundle between the tracker and its surroundings (dice inputs, display
// and statistics outputs).
interface dice_result_tracker_if #(
   parameter int COUNT_W = 8
);
   logic               button;
   logic [2:0]         throw;
   logic [2:0]         rd_face;
   logic [2:0]         result;
   logic               result_valid;
   logic               err;
   logic               busy;
   logic [6:0]         seg;
   logic [COUNT_W-1:0] rd_count;
   logic [COUNT_W-1:0] total_rolls;

   modport master (
      output button, throw, rd_face,
      input  result, result_valid, err, busy, seg, rd_count, total_rolls
   );

   modport slave (
      input  button, throw, rd_face,
      output result, result_valid, err, busy, seg, rd_count, total_rolls
   );
endinterface

// File: rtl/dice_seg_decoder.sv
// Combinational face-to-7-segment map; 0 and illegal faces show blank.
module dice_seg_decoder
   import dice_pkg::*;
(
   input  logic [2:0] face,
   output logic [6:0] seg
);

   // Face lookup
   always_comb begin
      seg = SEG_BLANK;
      case (face)
         3'd1:    seg = SEG_1;
         3'd2:    seg = SEG_2;
         3'd3:    seg = SEG_3;
         3'd4:    seg = SEG_4;
         3'd5:    seg = SEG_5;
         3'd6:    seg = SEG_6;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/dice_result_tracker.sv
// Captures the final dice face after each roll, drives the display and keeps
// saturating per-face and total statistics.
//
//   state   | meaning
//   --------+--------------------------------------------------------
//   IDLE    | waiting for the roll button
//   ROLLING | button held, dice still spinning
//   SETTLE  | button released, counting down before sampling throw
module dice_result_tracker
   import dice_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2,
   parameter int COUNT_W       = DEF_COUNT_W
)(
   input  logic clk,
   input  logic rst,
   dice_result_tracker_if.slave bus
);

   localparam logic [3:0]         SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
   localparam logic [COUNT_W-1:0] CNT_MAX     = '1;

   state_t             state_q, state_d;
   logic [3:0]         settle_q, settle_d;
   logic               sample;

   logic [2:0]         result_q;
   logic               valid_q;
   logic               err_q;
   logic [6:0]         seg_q;
   logic [6:0]         seg_next;
   logic [COUNT_W-1:0] face_cnt [1:6];
   logic [COUNT_W-1:0] total_q;

   dice_seg_decoder u_seg (
      .face (bus.throw),
      .seg  (seg_next)
   );

   // State register and settle counter
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         settle_q <= '0;
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
      end
   end

   // Next-state logic; sample marks the edge where throw is captured
   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      sample   = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.button) state_d = ROLLING;
         end
         ROLLING: begin
            if (!bus.button) begin
               state_d  = SETTLE;
               settle_d = SETTLE_LOAD;
            end
         end
         SETTLE: begin
            if (bus.button) begin
               state_d = ROLLING;
            end else if (settle_q == 4'd0) begin
               sample  = 1'b1;
               state_d = IDLE;
            end else begin
               settle_d = settle_q - 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Capture, pulses and saturating statistics
   always_ff @(posedge clk) begin
      if (!rst) begin
         result_q <= '0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
         seg_q    <= SEG_BLANK;
         total_q  <= '0;
         for (int i = 1; i <= 6; i++) face_cnt[i] <= '0;
      end else begin
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         if (sample) begin
            if (is_legal_face(bus.throw)) begin
               result_q <= bus.throw;
               seg_q    <= seg_next;
               valid_q  <= 1'b1;
               if (face_cnt[bus.throw] != CNT_MAX)
                  face_cnt[bus.throw] <= face_cnt[bus.throw] + 1'b1;
               if (total_q != CNT_MAX)
                  total_q <= total_q + 1'b1;
            end else begin
               err_q <= 1'b1;
            end
         end
      end
   end

   // Statistics read port
   always_comb begin
      bus.rd_count = '0;
      if (is_legal_face(bus.rd_face)) bus.rd_count = face_cnt[bus.rd_face];
   end

   assign bus.result       = result_q;
   assign bus.result_valid = valid_q;
   assign bus.err          = err_q;
   assign bus.seg          = seg_q;
   assign bus.total_rolls  = total_q;
   assign bus.busy         = (state_q != IDLE);

endmodule

// File: tb/tb_dice_result_tracker.sv
// Directed bench for dice_result_tracker (SETTLE_CYCLES=2, COUNT_W=8).
module tb_dice_result_tracker;

   localparam int CW = 8;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_fail;

   dice_result_tracker_if #(.COUNT_W(CW)) bus_if ();

   dice_result_tracker #(.SETTLE_CYCLES(2), .COUNT_W(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change on negedge; outputs are observed on negedge too.
   task automatic do_reset(input int cycles);
      @(negedge clk);
      rst = 1'b0;
      bus_if.button = 1'b0;
      repeat (cycles) @(negedge clk);
      rst = 1'b1;
   endtask

   // Press for press_cycles, release, then run 4 more cycles (covers E..E+3).
   task automatic roll(input int press_cycles, input logic [2:0] face,
                       output int rv_seen, output int err_seen);
      rv_seen  = 0;
      err_seen = 0;
      @(negedge clk);
      bus_if.button = 1'b1;
      bus_if.throw  = face;
      repeat (press_cycles) @(negedge clk);
      bus_if.button = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (bus_if.result_valid) rv_seen++;
         if (bus_if.err) err_seen++;
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      bus_if.button = 1'b1;
      bus_if.throw  = 3'd3;
      repeat (3) @(negedge clk);
      do_reset(3);
      n_chk++; if (bus_if.result !== 3'd0) begin n_fail++; $display("FAIL reset_result got %0d exp 0", bus_if.result); end
      n_chk++; if (bus_if.seg !== 7'b0000000) begin n_fail++; $display("FAIL reset_seg got %b exp 0000000", bus_if.seg); end
      n_chk++; if (bus_if.total_rolls !== 8'd0) begin n_fail++; $display("FAIL reset_total got %0d exp 0", bus_if.total_rolls); end
      n_chk++; if (bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", bus_if.busy); end
      n_chk++; if (bus_if.result_valid !== 1'b0 || bus_if.err !== 1'b0) begin n_fail++; $display("FAIL reset_pulses got rv=%b err=%b exp 0 0", bus_if.result_valid, bus_if.err); end
      for (int f = 1; f <= 6; f++) begin
         bus_if.rd_face = 3'(f);
         #1;
         n_chk++; if (bus_if.rd_count !== 8'd0) begin n_fail++; $display("FAIL reset_count face %0d got %0d exp 0", f, bus_if.rd_count); end
      end
   endtask

   task automatic test_legal_roll();
      do_reset(2);
      @(negedge clk);
      bus_if.button = 1'b1;
      bus_if.throw  = 3'd4;
      repeat (10) @(negedge clk);
      n_chk++; if (bus_if.busy !== 1'b1) begin n_fail++; $display("FAIL legal_busy_rolling got %b exp 1", bus_if.busy); end
      bus_if.button = 1'b0;
      @(negedge clk); // after E
      n_chk++; if (bus_if.result_valid !== 1'b0) begin n_fail++; $display("FAIL legal_rv_E got %b exp 0", bus_if.result_valid); end
      @(negedge clk); // after E+1
      n_chk++; if (bus_if.result_valid !== 1'b0) begin n_fail++; $display("FAIL legal_rv_E1 got %b exp 0", bus_if.result_valid); end
      @(negedge clk); // after E+2
      n_chk++; if (bus_if.result_valid !== 1'b1) begin n_fail++; $display("FAIL legal_rv_E2 got %b exp 1", bus_if.result_valid); end
      n_chk++; if (bus_if.result !== 3'd4) begin n_fail++; $display("FAIL legal_result got %0d exp 4", bus_if.result); end
      n_chk++; if (bus_if.seg !== 7'b1100110) begin n_fail++; $display("FAIL legal_seg got %b exp 1100110", bus_if.seg); end
      n_chk++; if (bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL legal_busy_after got %b exp 0", bus_if.busy); end
      @(negedge clk); // after E+3
      n_chk++; if (bus_if.result_valid !== 1'b0) begin n_fail++; $display("FAIL legal_rv_E3 got %b exp 0", bus_if.result_valid); end
      bus_if.rd_face = 3'd4;
      #1;
      n_chk++; if (bus_if.rd_count !== 8'd1) begin n_fail++; $display("FAIL legal_count4 got %0d exp 1", bus_if.rd_count); end
      n_chk++; if (bus_if.total_rolls !== 8'd1) begin n_fail++; $display("FAIL legal_total got %0d exp 1", bus_if.total_rolls); end
      bus_if.rd_face = 3'd0;
      #1;
      n_chk++; if (bus_if.rd_count !== 8'd0) begin n_fail++; $display("FAIL legal_rdface0 got %0d exp 0", bus_if.rd_count); end
      bus_if.rd_face = 3'd7;
      #1;
      n_chk++; if (bus_if.rd_count !== 8'd0) begin n_fail++; $display("FAIL legal_rdface7 got %0d exp 0", bus_if.rd_count); end
   endtask

   task automatic test_repress();
      int rv, er;
      rv = 0;
      er = 0;
      do_reset(2);
      @(negedge clk);
      bus_if.button = 1'b1;
      bus_if.throw  = 3'd5;
      repeat (4) @(negedge clk);
      bus_if.button = 1'b0;
      @(negedge clk); // after E, in SETTLE
      bus_if.button = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (bus_if.result_valid) rv++;
         if (bus_if.err) er++;
      end
      n_chk++; if (bus_if.busy !== 1'b1) begin n_fail++; $display("FAIL repress_busy got %b exp 1", bus_if.busy); end
      n_chk++; if (rv !== 0 || er !== 0) begin n_fail++; $display("FAIL repress_pulses got rv=%0d err=%0d exp 0 0", rv, er); end
      n_chk++; if (bus_if.total_rolls !== 8'd0) begin n_fail++; $display("FAIL repress_total_mid got %0d exp 0", bus_if.total_rolls); end
      bus_if.throw  = 3'd2;
      bus_if.button = 1'b0;
      rv = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (bus_if.result_valid) rv++;
      end
      n_chk++; if (rv !== 1) begin n_fail++; $display("FAIL repress_rv got %0d exp 1", rv); end
      n_chk++; if (bus_if.result !== 3'd2) begin n_fail++; $display("FAIL repress_result got %0d exp 2", bus_if.result); end
      n_chk++; if (bus_if.total_rolls !== 8'd1) begin n_fail++; $display("FAIL repress_total got %0d exp 1", bus_if.total_rolls); end
   endtask

   // Continues from test_repress state: result=2, count(2)=1, total=1.
   task automatic test_illegal();
      int rv, er;
      logic [7:0] exp_cnt [1:6];
      exp_cnt = '{8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
      roll(3, 3'd0, rv, er);
      n_chk++; if (rv !== 0 || er !== 1) begin n_fail++; $display("FAIL illegal0_pulses got rv=%0d err=%0d exp 0 1", rv, er); end
      roll(3, 3'd7, rv, er);
      n_chk++; if (rv !== 0 || er !== 1) begin n_fail++; $display("FAIL illegal7_pulses got rv=%0d err=%0d exp 0 1", rv, er); end
      n_chk++; if (bus_if.result !== 3'd2) begin n_fail++; $display("FAIL illegal_result got %0d exp 2", bus_if.result); end
      n_chk++; if (bus_if.seg !== 7'b1011011) begin n_fail++; $display("FAIL illegal_seg got %b exp 1011011", bus_if.seg); end
      n_chk++; if (bus_if.total_rolls !== 8'd1) begin n_fail++; $display("FAIL illegal_total got %0d exp 1", bus_if.total_rolls); end
      for (int f = 1; f <= 6; f++) begin
         bus_if.rd_face = 3'(f);
         #1;
         n_chk++; if (bus_if.rd_count !== exp_cnt[f]) begin n_fail++; $display("FAIL illegal_count face %0d got %0d exp %0d", f, bus_if.rd_count, exp_cnt[f]); end
      end
   endtask

   task automatic test_saturation();
      int rv, er;
      do_reset(2);
      for (int r = 0; r < 300; r++) begin
         roll(1, 3'd6, rv, er);
         n_chk++; if (rv !== 1 || er !== 0) begin n_fail++; $display("FAIL sat_pulse roll %0d got rv=%0d err=%0d exp 1 0", r, rv, er); end
      end
      bus_if.rd_face = 3'd6;
      #1;
      n_chk++; if (bus_if.rd_count !== 8'd255) begin n_fail++; $display("FAIL sat_count6 got %0d exp 255", bus_if.rd_count); end
      n_chk++; if (bus_if.total_rolls !== 8'd255) begin n_fail++; $display("FAIL sat_total got %0d exp 255", bus_if.total_rolls); end
      n_chk++; if (bus_if.seg !== 7'b1111101) begin n_fail++; $display("FAIL sat_seg got %b exp 1111101", bus_if.seg); end
      for (int f = 1; f <= 5; f++) begin
         bus_if.rd_face = 3'(f);
         #1;
         n_chk++; if (bus_if.rd_count !== 8'd0) begin n_fail++; $display("FAIL sat_other face %0d got %0d exp 0", f, bus_if.rd_count); end
      end
   endtask

   task automatic test_reset_mid();
      int rv, er;
      rv = 0;
      er = 0;
      do_reset(2);
      @(negedge clk);
      bus_if.button = 1'b1;
      bus_if.throw  = 3'd5;
      repeat (3) @(negedge clk);
      bus_if.button = 1'b0;
      @(negedge clk); // after E, in SETTLE
      n_chk++; if (bus_if.busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_settle got %b exp 1", bus_if.busy); end
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (bus_if.result_valid) rv++;
         if (bus_if.err) er++;
      end
      n_chk++; if (rv !== 0 || er !== 0) begin n_fail++; $display("FAIL mid_pulses got rv=%0d err=%0d exp 0 0", rv, er); end
      n_chk++; if (bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy got %b exp 0", bus_if.busy); end
      n_chk++; if (bus_if.result !== 3'd0) begin n_fail++; $display("FAIL mid_result got %0d exp 0", bus_if.result); end
      n_chk++; if (bus_if.total_rolls !== 8'd0) begin n_fail++; $display("FAIL mid_total got %0d exp 0", bus_if.total_rolls); end
      bus_if.rd_face = 3'd5;
      #1;
      n_chk++; if (bus_if.rd_count !== 8'd0) begin n_fail++; $display("FAIL mid_count5 got %0d exp 0", bus_if.rd_count); end
      rst = 1'b1;
      roll(2, 3'd3, rv, er);
      n_chk++; if (rv !== 1 || er !== 0) begin n_fail++; $display("FAIL mid_after_pulses got rv=%0d err=%0d exp 1 0", rv, er); end
      n_chk++; if (bus_if.result !== 3'd3) begin n_fail++; $display("FAIL mid_after_result got %0d exp 3", bus_if.result); end
      n_chk++; if (bus_if.seg !== 7'b1001111) begin n_fail++; $display("FAIL mid_after_seg got %b exp 1001111", bus_if.seg); end
      n_chk++; if (bus_if.total_rolls !== 8'd1) begin n_fail++; $display("FAIL mid_after_total got %0d exp 1", bus_if.total_rolls); end
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      rst = 1'b0;
      bus_if.button  = 1'b0;
      bus_if.throw   = 3'd0;
      bus_if.rd_face = 3'd0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      test_reset();
      test_legal_roll();
      test_repress();
      test_illegal();
      test_saturation();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
